// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared widths, state encoding and grant helpers for the 4-way round-robin mux arbiter.
package mux4_rr_arbiter_pkg;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned SELW  = 2;
  localparam int unsigned HOLDW = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  // Index of the set bit in a one-hot grant; returns 0 for an all-zero vector.
  function automatic logic [SELW-1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
    logic [SELW-1:0] idx;
    idx = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (oh[i]) idx = SELW'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mux4_rr_arbiter_mux4_sel.sv
// Combinational 4:1 single-bit mux driven by the arbiter's registered select.
module mux4_sel (
  input  logic i0,
  input  logic i1,
  input  logic i2,
  input  logic i3,
  input  logic s1,
  input  logic s0,
  output logic out
);

  // Select one of four data bits by {s1,s0}.
  always_comb begin
    out = s1 ? (s0 ? i3 : i2) : (s0 ? i1 : i0);
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sequencing a shared 4:1 mux with per-tenure hold limit.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] din,
  output logic [NREQ-1:0] gnt,
  output logic            s1,
  output logic            s0,
  output logic            valid,
  output logic            out
);

  state_e            state_q, state_d;
  logic [SELW-1:0]   ptr_q, ptr_d;
  logic [HOLDW-1:0]  hold_q, hold_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [SELW-1:0]   sel_q, sel_d;
  logic              valid_q, valid_d;
  logic [SELW:0]     pick;
  logic              grant_new;
  logic              mux_out;

  // First requesting index at or after p (mod 4), skipping excluded bits; MSB flags a hit.
  function automatic logic [SELW:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [SELW-1:0] p,
                                            input logic [NREQ-1:0] excl);
    logic [NREQ-1:0] cand;
    logic [SELW-1:0] idx;
    logic [SELW:0]   res;
    cand = r & ~excl;
    res  = '0;
    for (int k = int'(NREQ) - 1; k >= 0; k--) begin
      idx = p + SELW'(k);
      if (cand[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  // Next-state: arbitrate from IDLE, on hold expiry with waiters, or on release with handoff.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    gnt_d   = gnt_q;
    pick    = '0;

    if (state_q == IDLE) begin
      if (|req) pick = rr_pick(req, ptr_q, '0);
    end else begin
      if (req[sel_q]) begin
        if (hold_q < HOLDW'(MAX_HOLD)) begin
          hold_d = hold_q + HOLDW'(1);
        end else if (|(req & ~gnt_q)) begin
          pick = rr_pick(req, ptr_q, gnt_q);
        end else begin
          hold_d = HOLDW'(1);
        end
      end else if (|req) begin
        pick = rr_pick(req, ptr_q, '0);
      end else begin
        state_d = IDLE;
        gnt_d   = '0;
        hold_d  = '0;
      end
    end

    grant_new = pick[SELW];
    if (grant_new) begin
      state_d = GRANT;
      gnt_d   = NREQ'(1) << pick[SELW-1:0];
      ptr_d   = pick[SELW-1:0] + SELW'(1);
      hold_d  = HOLDW'(1);
    end

    // Select follows the grant on the same edge; it is retained through IDLE.
    sel_d   = (|gnt_d) ? onehot_to_idx(gnt_d) : sel_q;
    valid_d = |gnt_d;
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      hold_q  <= '0;
      gnt_q   <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
    end
  end

  mux4_sel u_mux (
    .i0  (din[0]),
    .i1  (din[1]),
    .i2  (din[2]),
    .i3  (din[3]),
    .s1  (sel_q[1]),
    .s0  (sel_q[0]),
    .out (mux_out)
  );

  assign gnt   = gnt_q;
  assign s1    = sel_q[1];
  assign s0    = sel_q[0];
  assign valid = valid_q;
  assign out   = valid_q & mux_out;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed self-checking bench for mux4_rr_arbiter with MAX_HOLD = 4.
module tb_mux4_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] din;
  logic [3:0] gnt;
  logic       s1;
  logic       s0;
  logic       valid;
  logic       out;

  int n_checks;
  int n_errors;

  mux4_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .din   (din),
    .gnt   (gnt),
    .s1    (s1),
    .s0    (s0),
    .valid (valid),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %b expected %b", tag, got, exp);
    end
  endtask

  // Advance one clock edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Clean reset pulse; returns just after a rising edge with rst low.
  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    req = 4'b0000;
    din = 4'b0000;
    step();
    step();

    // Reset state
    check("rst_gnt",   gnt, 4'b0000);
    check("rst_sel",   {2'b00, s1, s0}, 4'b0000);
    check("rst_valid", {3'b000, valid}, 4'b0000);
    check("rst_out",   {3'b000, out}, 4'b0000);
    rst = 1'b0;

    // Grant requester 2 then assert reset mid-tenure
    req = 4'b0100;
    din = 4'b0100;
    step();
    check("pre_rst_gnt", gnt, 4'b0100);
    check("pre_rst_out", {3'b000, out}, 4'b0001);
    step();
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_gnt", gnt, 4'b0000);
    check("async_rst_sel", {2'b00, s1, s0}, 4'b0000);
    check("async_rst_out", {3'b000, out}, 4'b0000);
    step();
    rst = 1'b0;
    step();
    check("post_rst_gnt", gnt, 4'b0100);
    check("post_rst_sel", {2'b00, s1, s0}, 4'b0010);

    // Single requester holds indefinitely
    do_reset();
    req = 4'b0010;
    din = 4'b0010;
    for (int c = 0; c < 10; c++) begin
      step();
      check("single_gnt", gnt, 4'b0010);
      check("single_sel", {2'b00, s1, s0}, 4'b0001);
      check("single_out", {3'b000, out}, 4'b0001);
    end
    req = 4'b0000;
    step();
    check("idle_gnt",   gnt, 4'b0000);
    check("idle_valid", {3'b000, valid}, 4'b0000);
    check("idle_sel",   {2'b00, s1, s0}, 4'b0001);
    check("idle_out",   {3'b000, out}, 4'b0000);

    // All requesting: rotation 0,1,2,3,0 with 4-cycle tenures
    do_reset();
    req = 4'b1111;
    din = 4'b0000;
    for (int c = 0; c < 20; c++) begin
      logic [3:0] exp_g;
      exp_g = 4'b0001 << ((c / 4) % 4);
      step();
      check("rr_gnt",   gnt, exp_g);
      check("rr_valid", {3'b000, valid}, 4'b0001);
    end

    // Early release hands off on the same edge
    do_reset();
    req = 4'b0011;
    step();
    check("early_gnt0", gnt, 4'b0001);
    step();
    check("early_gnt1", gnt, 4'b0001);
    req = 4'b0010;
    step();
    check("handoff_gnt",   gnt, 4'b0010);
    check("handoff_valid", {3'b000, valid}, 4'b0001);
    check("handoff_sel",   {2'b00, s1, s0}, 4'b0001);

    // Data path follows granted din combinationally
    do_reset();
    req = 4'b1000;
    din = 4'b1000;
    step();
    check("dp_gnt", gnt, 4'b1000);
    check("dp_sel", {2'b00, s1, s0}, 4'b0011);
    check("dp_out_hi", {3'b000, out}, 4'b0001);
    din = 4'b0111;
    #1;
    check("dp_out_lo", {3'b000, out}, 4'b0000);
    din = 4'b0000;
    #1;
    check("dp_ungranted", {3'b000, out}, 4'b0000);
    din = 4'b1111;
    #1;
    check("dp_out_hi2", {3'b000, out}, 4'b0001);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
